// File: rtl/rf_wport_arb_pkg.sv
// rf_wport_arb_pkg: shared widths, zero-register constant and aux FIFO entry type
package rf_wport_arb_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam logic [ADDR_W-1:0] REG_ZERO = '0;
   typedef struct packed {
      logic              valid;
      logic              live;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;
endpackage

// File: rtl/rf_wport_arb_if.sv
// rf_wport_arb_if: writeback, aux request, GRF write port and hazard lookup bundle
// master (requesters/hazard unit) drives wb_*, aux_valid/a/wd, q_a1/q_a2
// slave (arbiter) drives aux_ready, rf_we/a/wd, q_hit1/q_hit2, pend_cnt
interface rf_wport_arb_if #(parameter int DEPTH = 2);
   import rf_wport_arb_pkg::*;
   logic                     wb_we;
   logic [ADDR_W-1:0]        wb_a;
   logic [DATA_W-1:0]        wb_wd;
   logic                     aux_valid;
   logic [ADDR_W-1:0]        aux_a;
   logic [DATA_W-1:0]        aux_wd;
   logic                     aux_ready;
   logic                     rf_we;
   logic [ADDR_W-1:0]        rf_a;
   logic [DATA_W-1:0]        rf_wd;
   logic [ADDR_W-1:0]        q_a1;
   logic [ADDR_W-1:0]        q_a2;
   logic                     q_hit1;
   logic                     q_hit2;
   logic [$clog2(DEPTH):0]   pend_cnt;
   modport master (
      output wb_we, wb_a, wb_wd, aux_valid, aux_a, aux_wd, q_a1, q_a2,
      input  aux_ready, rf_we, rf_a, rf_wd, q_hit1, q_hit2, pend_cnt
   );
   modport slave (
      input  wb_we, wb_a, wb_wd, aux_valid, aux_a, aux_wd, q_a1, q_a2,
      output aux_ready, rf_we, rf_a, rf_wd, q_hit1, q_hit2, pend_cnt
   );
endinterface

// File: rtl/rf_wport_arb_aux_wfifo.sv
// aux_wfifo: DEPTH-entry aux write buffer with kill-by-address and pending-write lookups
// i_clk/i_rst_n: clock, async active-low reset
// i_push/i_push_live/i_push_a/i_push_wd: enqueue at tail (caller guarantees not full)
// i_pop: retire head (caller guarantees head valid)
// i_kill/i_kill_a: clear live on every entry addressed i_kill_a
// i_q_a1/i_q_a2 -> o_hit1/o_hit2: live pending write to that register
// o_head: head entry, o_cnt: occupied entries including killed ones
module aux_wfifo
   import rf_wport_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_push,
   input  logic                   i_push_live,
   input  logic [ADDR_W-1:0]      i_push_a,
   input  logic [DATA_W-1:0]      i_push_wd,
   input  logic                   i_pop,
   input  logic                   i_kill,
   input  logic [ADDR_W-1:0]      i_kill_a,
   input  logic [ADDR_W-1:0]      i_q_a1,
   input  logic [ADDR_W-1:0]      i_q_a2,
   output entry_t                 o_head,
   output logic [$clog2(DEPTH):0] o_cnt,
   output logic                   o_hit1,
   output logic                   o_hit2
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   entry_t             r_q [DEPTH];
   logic [PTR_W-1:0]   r_rd;
   logic [PTR_W-1:0]   r_wr;
   logic [CNT_W-1:0]   r_cnt;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         // a push in the same edge overrides the kill; its live bit already accounts for it
         for (int i = 0; i < DEPTH; i++)
            if (i_kill && r_q[i].addr == i_kill_a) r_q[i].live <= 1'b0;
         if (i_pop) r_q[r_rd].valid <= 1'b0;
         if (i_push) r_q[r_wr] <= '{valid: 1'b1, live: i_push_live, addr: i_push_a, data: i_push_wd};
         r_rd  <= r_rd + PTR_W'(i_pop);
         r_wr  <= r_wr + PTR_W'(i_push);
         r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
      end
   assign o_head = r_q[r_rd];
   assign o_cnt  = r_cnt;
   always_comb begin
      o_hit1 = 1'b0;
      o_hit2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         o_hit1 = o_hit1 | (r_q[i].valid && r_q[i].live && r_q[i].addr == i_q_a1);
         o_hit2 = o_hit2 | (r_q[i].valid && r_q[i].live && r_q[i].addr == i_q_a2);
      end
      o_hit1 = o_hit1 && i_q_a1 != REG_ZERO;
      o_hit2 = o_hit2 && i_q_a2 != REG_ZERO;
   end
endmodule

// File: rtl/rf_wport_arb.sv
// rf_wport_arb: GPR write-port arbiter, writeback first, buffered aux writes drain into idle cycles
// i_clk/i_rst_n: clock, async active-low reset
// io_bus (slave): wb_* writeback, aux_* request/ready, rf_* GRF write port,
//                 q_a*/q_hit* hazard lookups, pend_cnt buffered entries
module rf_wport_arb
   import rf_wport_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   rf_wport_arb_if.slave  io_bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   entry_t             w_head;
   logic [CNT_W-1:0]   w_cnt;
   logic               w_busy;
   logic               w_pop;
   logic               w_head_wr;
   logic               w_push;
   logic               w_push_live;
   // writes to $0 never occupy the port
   assign w_busy      = io_bus.wb_we && io_bus.wb_a != REG_ZERO;
   // killed heads still consume a free slot so they cannot block the queue
   assign w_pop       = !w_busy && w_head.valid;
   assign w_head_wr   = w_pop && w_head.live;
   assign io_bus.aux_ready = w_cnt != CNT_W'(DEPTH);
   assign w_push      = io_bus.aux_valid && io_bus.aux_ready;
   // a same-cycle WB write to the same register is younger, so the aux entry is dead on arrival
   assign w_push_live = io_bus.aux_a != REG_ZERO && !(w_busy && io_bus.wb_a == io_bus.aux_a);
   assign io_bus.rf_we    = w_busy || w_head_wr;
   assign io_bus.rf_a     = w_busy ? io_bus.wb_a  : w_head_wr ? w_head.addr : REG_ZERO;
   assign io_bus.rf_wd    = w_busy ? io_bus.wb_wd : w_head_wr ? w_head.data : '0;
   assign io_bus.pend_cnt = w_cnt;
   aux_wfifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (w_push),
      .i_push_live (w_push_live),
      .i_push_a    (io_bus.aux_a),
      .i_push_wd   (io_bus.aux_wd),
      .i_pop       (w_pop),
      .i_kill      (w_busy),
      .i_kill_a    (io_bus.wb_a),
      .i_q_a1      (io_bus.q_a1),
      .i_q_a2      (io_bus.q_a2),
      .o_head      (w_head),
      .o_cnt       (w_cnt),
      .o_hit1      (io_bus.q_hit1),
      .o_hit2      (io_bus.q_hit2)
   );
endmodule

// File: tb/tb_rf_wport_arb.sv
// tb_rf_wport_arb: directed plus random stimulus against a queue-based model of the arbiter
module tb_rf_wport_arb;
   import rf_wport_arb_pkg::*;
   localparam int DEPTH = 2;
   typedef struct {
      logic              live;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } m_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   m_t   mq[$];
   rf_wport_arb_if #(.DEPTH(DEPTH)) bus ();
   rf_wport_arb #(.DEPTH(DEPTH)) dut (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else n_pass++;
   endtask
   function automatic logic model_hit(input logic [ADDR_W-1:0] q);
      if (q == 0) return 1'b0;
      foreach (mq[i]) if (mq[i].live && mq[i].addr == q) return 1'b1;
      return 1'b0;
   endfunction
   // drives one cycle's inputs, checks outputs against the model, then advances across one edge
   task automatic step(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                       input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic [ADDR_W-1:0] q1, input logic [ADDR_W-1:0] q2);
      logic busy, e_ready, e_we, live;
      logic [ADDR_W-1:0] e_a;
      logic [DATA_W-1:0] e_wd;
      bus.wb_we = we; bus.wb_a = a; bus.wb_wd = wd;
      bus.aux_valid = av; bus.aux_a = aa; bus.aux_wd = ad;
      bus.q_a1 = q1; bus.q_a2 = q2;
      #1;
      busy = we && a != 0;
      e_ready = mq.size() < DEPTH;
      e_we = 1'b0; e_a = '0; e_wd = '0;
      if (busy) begin
         e_we = 1'b1; e_a = a; e_wd = wd;
      end else if (mq.size() > 0 && mq[0].live) begin
         e_we = 1'b1; e_a = mq[0].addr; e_wd = mq[0].data;
      end
      check("rf_we", 64'(bus.rf_we), 64'(e_we));
      check("rf_a", 64'(bus.rf_a), 64'(e_a));
      check("rf_wd", 64'(bus.rf_wd), 64'(e_wd));
      check("aux_ready", 64'(bus.aux_ready), 64'(e_ready));
      check("pend_cnt", 64'(bus.pend_cnt), 64'(mq.size()));
      check("q_hit1", 64'(bus.q_hit1), 64'(model_hit(q1)));
      check("q_hit2", 64'(bus.q_hit2), 64'(model_hit(q2)));
      if (busy) foreach (mq[i]) if (mq[i].addr == a) mq[i].live = 1'b0;
      if (!busy && mq.size() > 0) void'(mq.pop_front());
      if (av && e_ready) begin
         live = aa != 0 && !(busy && a == aa);
         mq.push_back('{live: live, addr: aa, data: ad});
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      bus.wb_we = 0; bus.wb_a = 0; bus.wb_wd = 0;
      bus.aux_valid = 0; bus.aux_a = 0; bus.aux_wd = 0;
      bus.q_a1 = 0; bus.q_a2 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pend", 64'(bus.pend_cnt), 64'd0);
      check("rst_ready", 64'(bus.aux_ready), 64'd1);
      check("rst_rf_we", 64'(bus.rf_we), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // WB-only traffic
      step(1, 8, 32'h1234, 0, 0, 0, 8, 0);
      // single aux write drains next cycle
      step(0, 0, 0, 1, 9, 32'hAA, 9, 0);
      step(0, 0, 0, 0, 0, 0, 9, 0);
      step(0, 0, 0, 0, 0, 0, 9, 0);
      // fill while WB busy, third blocked until a slot frees
      step(1, 10, 32'h10, 1, 3, 32'h33, 3, 4);
      step(1, 10, 32'h11, 1, 4, 32'h44, 3, 4);
      step(1, 10, 32'h12, 1, 5, 32'h55, 3, 5);
      step(0, 0, 0, 1, 5, 32'h55, 3, 5);
      step(0, 0, 0, 1, 5, 32'h55, 4, 5);
      step(0, 0, 0, 0, 0, 0, 5, 0);
      step(0, 0, 0, 0, 0, 0, 5, 0);
      // pending entry overtaken by WB
      step(0, 0, 0, 1, 6, 32'h66, 6, 0);
      step(1, 6, 32'h77, 0, 0, 0, 6, 0);
      step(0, 0, 0, 0, 0, 0, 6, 0);
      step(0, 0, 0, 0, 0, 0, 6, 0);
      // same-cycle collision and aux to $0
      step(1, 7, 32'h70, 1, 7, 32'hBB, 7, 0);
      step(0, 0, 0, 1, 0, 32'hCC, 7, 0);
      step(0, 0, 0, 0, 0, 0, 7, 0);
      step(0, 0, 0, 0, 0, 0, 7, 0);
      // async reset with two pending entries
      step(1, 11, 32'h1B, 1, 12, 32'hC0, 12, 13);
      step(1, 11, 32'h1C, 1, 13, 32'hD0, 12, 13);
      bus.wb_we = 0; bus.aux_valid = 0; bus.q_a1 = 12; bus.q_a2 = 13;
      #1;
      check("pre_rst_hit1", 64'(bus.q_hit1), 64'd1);
      check("pre_rst_pend", 64'(bus.pend_cnt), 64'd2);
      rst_n = 1'b0;
      #1;
      check("arst_pend", 64'(bus.pend_cnt), 64'd0);
      check("arst_hit1", 64'(bus.q_hit1), 64'd0);
      check("arst_hit2", 64'(bus.q_hit2), 64'd0);
      check("arst_ready", 64'(bus.aux_ready), 64'd1);
      check("arst_rf_we", 64'(bus.rf_we), 64'd0);
      mq.delete();
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(0, 0, 0, 0, 0, 0, 12, 13);
      step(0, 0, 0, 0, 0, 0, 12, 13);
      // random traffic over a narrow address range to force collisions
      for (int k = 0; k < 400; k++)
         step($urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, 5)), $urandom(),
              $urandom_range(0, 2) != 0, ADDR_W'($urandom_range(0, 5)), $urandom(),
              ADDR_W'($urandom_range(0, 5)), ADDR_W'($urandom_range(0, 5)));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/rf_wport_arb.md
Name: rf_wport_arb

Overview:
- Arbiter for the single GPR write port fed by the writeback stage.
- Pipeline writeback (RegWrite/WD with its destination) has absolute priority and is never back-pressured.
- A secondary "aux" requester (multi-cycle unit result) is buffered in a small FIFO and drained into idle write-port cycles.
- Exports pending-write lookups so the hazard unit can stall readers of buffered destinations.

Parameters:
DEPTH, 2, aux FIFO entries (power of two, >=2)
DATA_W, 32, write-data width
ADDR_W, 5, register-address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
wb_we  in  1  writeback RegWrite
wb_a  in  ADDR_W  writeback destination register
wb_wd  in  DATA_W  writeback WD
aux_valid  in  1  aux write request
aux_a  in  ADDR_W  aux destination
aux_wd  in  DATA_W  aux data
aux_ready  out  1  aux request accepted this cycle when high with aux_valid
rf_we  out  1  GRF write enable
rf_a  out  ADDR_W  GRF write address
rf_wd  out  DATA_W  GRF write data
q_a1  in  ADDR_W  hazard lookup address 1 (rs)
q_a2  in  ADDR_W  hazard lookup address 2 (rt)
q_hit1  out  1  live pending aux write to q_a1
q_hit2  out  1  live pending aux write to q_a2
pend_cnt  out  log2(DEPTH)+1  occupied FIFO entries, including killed ones

Behaviour:
- Reset (async, reset==0): all entries invalid, rd/wr pointers 0, pend_cnt=0, q_hit*=0, aux_ready=1. rf_* stay combinational from wb_* (FIFO empty). Reset mid-operation discards buffered entries; no write is issued for them.
- Port busy: WB owns the port when wb_we==1 && wb_a!=0. WB writes to $0 leave the port free.
- When WB owns the port: rf_we=1, rf_a=wb_a, rf_wd=wb_wd, same cycle (zero latency).
- When the port is free and the head entry is valid and live: rf_we=1, rf_a/rf_wd from head. Head pops at the next edge.
- When the port is free and the head is killed: rf_we=0. Head pops at the next edge, so the drain slot is consumed.
- Otherwise rf_we=0 and rf_a/rf_wd are don't-care (drive 0).
- aux_ready = (pend_cnt != DEPTH), derived from registered state only. No enqueue when full, even if a pop occurs the same cycle.
- Enqueue happens at the edge where aux_valid && aux_ready.
  - Entry stored live, unless aux_a==0 or (WB owns the port && wb_a==aux_a). In either case it is stored killed.
  - Earliest write of an accepted entry is the cycle after acceptance; there is no same-cycle bypass.
- Ordering rule: an accepted aux write is older than any WB write in the same or a later cycle.
  - Every edge where WB owns the port kills all live entries whose address equals wb_a.
  - The head is never written in a cycle where WB owns the port, so no stale overwrite can occur.
- Simultaneous enqueue and pop: both occur; pend_cnt unchanged.
- Pointers wrap modulo DEPTH. pend_cnt ranges 0..DEPTH.
- q_hitN = (q_aN != 0) && any entry is valid, live and has address q_aN. Combinational from registered state.
- Starvation of aux is allowed. Liveness is the hazard unit's job: it stalls on q_hit*.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, REG_ZERO constant, and entry struct {valid, live, addr, data}.
- One sub-module, aux_wfifo. It holds the DEPTH-entry storage, pointers, count, per-entry kill-by-address, and the two match lookups. rf_wport_arb keeps the port mux, busy decode and handshake.

Test Plan:
1. WB-only traffic, aux_valid=0: wb_we=1, wb_a=8, wb_wd=0x1234 -> rf_we=1, rf_a=8, rf_wd=0x1234 same cycle; pend_cnt stays 0.
2. aux_valid one cycle, aux_a=9, aux_wd=0xAA, WB idle -> pend_cnt=1 and q_a1=9 gives q_hit1=1 next cycle. That cycle rf_we=1, rf_a=9, rf_wd=0xAA; pend_cnt=0 after.
3. Back-to-back aux requests to 3, 4, 5 with WB busy on reg 10 -> first two accepted, aux_ready=0 on the third. After WB goes idle: writes 3 then 4 in consecutive cycles, and the third is accepted once not full.
4. Aux entry to reg 6 pending, WB writes reg 6 (0x77) -> GRF sees only 0x77. The entry is killed, q_hit1(q_a1=6)=0, and it drains with rf_we=0 in one free cycle.
5. Same-cycle aux_a=7 and WB wb_a=7 -> aux accepted but killed; reg 7 ends as the WB value. aux_a=0 -> accepted, never written.
6. Reset asserted with 2 pending entries -> pend_cnt=0, q_hit*=0 immediately (async). No aux write after release; aux_ready=1.
